ret_stack: RTL and testbench
============================

RET_STACK -- requirements
Module: ret_stack

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 3, setting the log2 of the entry count (DEPTH = 2**DEPTH_LOG2, 8 by default).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-004 SHALL have port call, input, 1, push request; same signal that selects the call target for the next PC.
REQ-005 SHALL have port ret, input, 1, pop request; same signal that selects addr_ret as the next PC.
REQ-006 SHALL have port pc_plus1, input, 16, return address to push on call.
REQ-007 SHALL have port stall, input, 1, pipeline hold; when 1, call and ret are ignored.
REQ-008 SHALL have port clr_err, input, 1, clears the sticky error flags.
REQ-009 SHALL have port addr_ret, output, 16, current top-of-stack address, feeding the next-PC return mux.
REQ-010 SHALL have port count, output, DEPTH_LOG2+1, number of valid entries, 0..DEPTH.
REQ-011 SHALL have port empty, output, 1, high when count == 0.
REQ-012 SHALL have port full, output, 1, high when count == DEPTH.
REQ-013 SHALL have port ovf, output, 1, sticky overflow flag.
REQ-014 SHALL have port unf, output, 1, sticky underflow flag.

Function
REQ-015 Storage SHALL be a circular buffer of DEPTH x 16-bit entries with a top pointer (tp, DEPTH_LOG2 bits) and a count register.
REQ-016 addr_ret SHALL be combinational: mem[tp] when count > 0, and 16'h0000 when count == 0; it has zero-cycle latency, so a ret consumes the pre-pop top in the same cycle.
REQ-017 A push (call=1, ret=0, stall=0) SHALL set tp <= tp+1 modulo DEPTH and mem[tp+1] <= pc_plus1, and SHALL increment count when count < DEPTH; the pushed value is visible on addr_ret the next cycle.
REQ-018 A push when full SHALL overwrite the oldest entry through pointer wrap-around, hold count at DEPTH, and set ovf.
REQ-019 A pop (ret=1, call=0, stall=0) with count > 0 SHALL set tp <= tp-1 modulo DEPTH and decrement count; entry contents are not cleared.
REQ-020 A pop when empty SHALL leave tp and count unchanged, drive addr_ret 16'h0000, and set unf.
REQ-021 When call=1 and ret=1 with stall=0 and count > 0, the block SHALL replace the top (mem[tp] <= pc_plus1) and leave tp, count, and the flags unchanged.
REQ-022 When call=1 and ret=1 with stall=0 and count == 0, the block SHALL behave as a push and SHALL NOT set unf.
REQ-023 When stall=1, the block SHALL leave all state unchanged regardless of call and ret.
REQ-024 clr_err=1 SHALL clear ovf and unf at the next edge; if an error event occurs in the same cycle, setting SHALL take priority over clearing.
REQ-025 empty and full SHALL be decoded combinationally from count.

Reset
REQ-026 While rst_n=0, the block SHALL asynchronously force tp=0, count=0, ovf=0, and unf=0; the outputs are then addr_ret=16'h0000, empty=1, and full=0.
REQ-027 Memory contents need not reset; since count=0, addr_ret is not affected by stale entries.
REQ-028 Reset asserted mid-operation SHALL discard all entries, and the first post-reset ret SHALL set unf.

Verification
REQ-029 Reset, then push 16'h0010, 16'h0020 -> count=2, addr_ret=16'h0020; one ret -> addr_ret=16'h0010, count=1.
REQ-030 Push 9 values 16'h0101..16'h0109 with DEPTH=8 -> full=1, ovf=1, count=8; 8 rets return 16'h0109 down to 16'h0102, then empty=1.
REQ-031 From empty, ret -> unf=1, addr_ret=16'h0000, count=0; then clr_err -> unf=0.
REQ-032 With top 16'h0030 and count=3, assert call and ret together with pc_plus1=16'h0055 -> addr_ret=16'h0055, count=3.
REQ-033 With call=1 and stall=1 for 4 cycles -> count and addr_ret unchanged.
REQ-034 With count=5, drop rst_n asynchronously between edges -> count=0 and empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ret_stack.sv
// Return-address stack: circular buffer that pushes on call and pops on ret. Top of stack is combinational (zero latency).
// Stall holds all state. A push when full overwrites the oldest entry and sets ovf; a pop when empty sets unf. Both flags are sticky.
module ret_stack #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  call,
    input  logic                  ret,
    input  logic [15:0]           pc_plus1,
    input  logic                  stall,
    input  logic                  clr_err,
    output logic [15:0]           addr_ret,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  ovf,
    output logic                  unf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] TP_ONE    = DEPTH_LOG2'(1);

    logic [15:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] tp_q, tp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_addr;
    logic                  is_empty, is_full;
    logic                  ovf_evt, unf_evt, clr_eff;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_CNT);

    always_comb begin
        tp_d    = tp_q;
        count_d = count_q;
        wr_en   = 1'b0;
        wr_addr = tp_q;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (!stall) begin
            // call+ret together on a non-empty stack is a tail call: replace the top in place
            if (call && ret && !is_empty) begin
                wr_en   = 1'b1;
                wr_addr = tp_q;
            end else if (call) begin
                tp_d    = tp_q + TP_ONE;
                wr_en   = 1'b1;
                wr_addr = tp_q + TP_ONE;
                if (is_full) begin
                    ovf_evt = 1'b1;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end else if (ret) begin
                if (is_empty) begin
                    unf_evt = 1'b1;
                end else begin
                    tp_d    = tp_q - TP_ONE;
                    count_d = count_q - CNT_ONE;
                end
            end
        end
        clr_eff = clr_err && !stall;
        ovf_d   = ovf_evt | (ovf_q & ~clr_eff);
        unf_d   = unf_evt | (unf_q & ~clr_eff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            tp_q    <= tp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entries are unreset storage; count gates visibility of stale data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= pc_plus1;
        end
    end

    assign addr_ret = is_empty ? 16'h0000 : mem_q[tp_q];
    assign count    = count_q;
    assign empty    = is_empty;
    assign full     = is_full;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule

// File: tb/tb_ret_stack.sv
// Bench for ret_stack: a queue-based reference model is checked on every falling edge, together with directed literal checks.
module tb_ret_stack;

    localparam int DL2   = 3;
    localparam int DEPTH = 1 << DL2;

    logic         clk;
    logic         rst_n;
    logic         call, ret, stall, clr_err;
    logic [15:0]  pc_plus1;
    logic [15:0]  addr_ret;
    logic [DL2:0] count;
    logic         empty, full, ovf, unf;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 0;

    logic [15:0] stk[$];
    logic        ovf_m, unf_m;

    ret_stack #(.DEPTH_LOG2(DL2)) dut (
        .clk(clk), .rst_n(rst_n), .call(call), .ret(ret), .pc_plus1(pc_plus1),
        .stall(stall), .clr_err(clr_err), .addr_ret(addr_ret), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_top();
        return (stk.size() > 0) ? stk[$] : 16'h0000;
    endfunction

    task automatic m_reset();
        stk.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic m_update(input logic c, input logic r, input logic [15:0] pc,
                            input logic s, input logic cl);
        logic eo, eu;
        eo = 1'b0;
        eu = 1'b0;
        if (!s) begin
            if (c && r && stk.size() > 0) begin
                stk[stk.size()-1] = pc;
            end else if (c) begin
                stk.push_back(pc);
                if (stk.size() > DEPTH) begin
                    void'(stk.pop_front());
                    eo = 1'b1;
                end
            end else if (r) begin
                if (stk.size() > 0) void'(stk.pop_back());
                else eu = 1'b1;
            end
            ovf_m = eo | (ovf_m & ~cl);
            unf_m = eu | (unf_m & ~cl);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_addr_ret", addr_ret, m_top());
            chk("m_count", count, stk.size());
            chk("m_empty", empty, stk.size() == 0);
            chk("m_full", full, stk.size() == DEPTH);
            chk("m_ovf", ovf, ovf_m);
            chk("m_unf", unf, unf_m);
        end
    end

    task automatic step(input logic c, input logic r, input logic [15:0] pc,
                        input logic s, input logic cl);
        call = c; ret = r; pc_plus1 = pc; stall = s; clr_err = cl;
        @(posedge clk);
        m_update(c, r, pc, s, cl);
        @(negedge clk);
        call = 1'b0; ret = 1'b0; stall = 1'b0; clr_err = 1'b0;
    endtask

    task automatic push(input logic [15:0] pc);
        step(1'b1, 1'b0, pc, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        call = 1'b0; ret = 1'b0; stall = 1'b0; clr_err = 1'b0; pc_plus1 = 16'h0000;
        m_reset();
        repeat (2) @(negedge clk);
        chk("rst_addr", addr_ret, 16'h0000);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);
        rst_n = 1'b1;
        chk_en = 1;

        // Basic push/pop.
        push(16'h0010);
        push(16'h0020);
        chk("pp_count2", count, 2);
        chk("pp_top20", addr_ret, 16'h0020);
        pop();
        chk("pp_top10", addr_ret, 16'h0010);
        chk("pp_count1", count, 1);
        pop();
        chk("pp_empty", empty, 1);

        // Overflow by nine pushes into eight entries.
        for (int i = 1; i <= 9; i++) push(16'h0100 + 16'(i));
        chk("of_full", full, 1);
        chk("of_ovf", ovf, 1);
        chk("of_count", count, 8);
        for (int i = 0; i < 8; i++) begin
            chk("of_pop_top", addr_ret, 16'h0109 - 16'(i));
            pop();
        end
        chk("of_empty", empty, 1);
        chk("of_addr0", addr_ret, 16'h0000);
        chk("of_unf_clean", unf, 0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("of_clr", ovf, 0);

        // Underflow and clear.
        pop();
        chk("uf_unf", unf, 1);
        chk("uf_addr", addr_ret, 16'h0000);
        chk("uf_count", count, 0);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("uf_clr", unf, 0);

        // Simultaneous call+ret replaces the top.
        push(16'h0010);
        push(16'h0020);
        push(16'h0030);
        chk("rp_top30", addr_ret, 16'h0030);
        step(1'b1, 1'b1, 16'h0055, 1'b0, 1'b0);
        chk("rp_top55", addr_ret, 16'h0055);
        chk("rp_count", count, 3);
        chk("rp_flags", {ovf, unf}, 2'b00);
        pop();
        chk("rp_below", addr_ret, 16'h0020);

        // Stall blocks call and ret.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 16'hAAAA, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        chk("st_count", count, 2);
        chk("st_top", addr_ret, 16'h0020);

        // call+ret on an empty stack acts as a push without underflow.
        pop();
        pop();
        step(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0);
        chk("ce_count", count, 1);
        chk("ce_top", addr_ret, 16'h0077);
        chk("ce_unf", unf, 0);

        // An overflow event in the same cycle as a clear keeps the flag set.
        for (int i = 0; i < 7; i++) push(16'h0200 + 16'(i));
        chk("pr_full", full, 1);
        step(1'b1, 1'b0, 16'h1234, 1'b0, 1'b1);
        chk("pr_ovf_kept", ovf, 1);
        chk("pr_top", addr_ret, 16'h1234);
        step(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk("pr_ovf_clr", ovf, 0);

        // Asynchronous reset asserted between clock edges.
        pop();
        pop();
        pop();
        chk("ar_count5", count, 5);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("ar_count0", count, 0);
        chk("ar_empty", empty, 1);
        chk("ar_addr", addr_ret, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pop();
        chk("ar_post_unf", unf, 1);
        chk("ar_post_count", count, 0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
